// File: rtl/audio_sigma_delta.sv
// audio_sigma_delta: multi-channel 1st/2nd-order sigma-delta DAC modulator fed through a one-deep frame buffer.
// Latency: an accepted frame is first used by the modulator on the next tick edge after the capture edge.
// Backpressure: sample_ready drops while a frame is pending and rises the cycle after the next tick drains it.
module audio_sigma_delta #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int SIGNED_IN = 1,
  parameter int ORDER     = 2,
  parameter int CLK_DIV   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [CHANNELS*WIDTH-1:0] sample_data,
  input  logic                      mute,
  output logic [CHANNELS-1:0]       dac_out
);

  // Parameter legality is enforced at elaboration so a bad build never reaches silicon.
  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("audio_sigma_delta: ORDER must be 1 or 2");
  end
  if (CHANNELS < 1 || CHANNELS > 8 || WIDTH < 8 || WIDTH > 24 ||
      CLK_DIV < 1 || CLK_DIV > 256) begin : g_bad_range
    $error("audio_sigma_delta: CHANNELS, WIDTH or CLK_DIV out of range");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

  // Second-order datapath: integrators are WIDTH+4 bits, sums are formed two bits wider
  // so that the saturation compare always sees the true (unwrapped) result.
  localparam int IW = WIDTH + 4;
  localparam int EW = WIDTH + 6;
  localparam logic signed [EW-1:0] MID_E  = EW'(2 ** (WIDTH - 1));
  localparam logic signed [EW-1:0] SAT_HI = EW'(2 ** (WIDTH + 2) - 1);
  localparam logic signed [EW-1:0] SAT_LO = EW'(-(2 ** (WIDTH + 2)));

  function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v);
    return (SIGNED_IN != 0) ? (v ^ MID) : v;
  endfunction

  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_HI) return IW'(SAT_HI);
    if (v < SAT_LO) return IW'(SAT_LO);
    return IW'(v);
  endfunction

  // ---------------------------------------------------------------- tick divider
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Counter runs 0..CLK_DIV-1 and wraps in the tick cycle.
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  // ---------------------------------------------------------------- frame buffer
  logic                      pend_full_q, pend_full_d;
  logic [CHANNELS*WIDTH-1:0] pend_q, pend_d;
  logic                      accept;
  logic                      load;

  assign sample_ready = !pend_full_q;
  assign accept       = sample_valid && sample_ready;
  assign load         = tick && pend_full_q;

  // Capture when empty; a tick moves the pending frame into the active registers.
  always_comb begin
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    if (load) pend_full_d = 1'b0;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_d      = sample_data;
    end
  end

  // Pending frame registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_full_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
    end
  end

  // ---------------------------------------------------------------- per-channel modulators
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] pend_x;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] x;
    logic             dac_q;

    // Active holds offset-binary values; on a load tick the modulator already sees the new frame.
    assign pend_x = to_offset(pend_q[ch*WIDTH +: WIDTH]);
    assign act_d  = load ? pend_x : act_q;
    assign x      = mute ? MID : act_d;
    assign dac_out[ch] = dac_q;

    // Active sample register; mute never alters it so the stream resumes on unmute.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) act_q <= MID;
      else          act_q <= act_d;
    end

    if (ORDER == 1) begin : g_o1
      logic [WIDTH-1:0] acc_q, acc_d;
      logic             dac_d;

      // First order: the accumulator carry is the output bit.
      always_comb begin
        {dac_d, acc_d} = {1'b0, acc_q} + {1'b0, x};
      end

      // Accumulator and output advance only on ticks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          acc_q <= '0;
          dac_q <= 1'b0;
        end else if (tick) begin
          acc_q <= acc_d;
          dac_q <= dac_d;
        end
      end
    end else begin : g_o2
      logic signed [IW-1:0] i1_q, i2_q, i1_d, i2_d;
      logic signed [EW-1:0] xs, fb;

      // Second order: two saturating integrators, feedback from the current output bit.
      always_comb begin
        xs   = $signed(EW'(x)) - MID_E;
        fb   = dac_q ? MID_E : -MID_E;
        i1_d = sat(EW'(i1_q) + xs - fb);
        i2_d = sat(EW'(i2_q) + EW'(i1_d) - fb);
      end

      // Integrators and output advance only on ticks; output is the sign of the new i2.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          i1_q  <= '0;
          i2_q  <= '0;
          dac_q <= 1'b0;
        end else if (tick) begin
          i1_q  <= i1_d;
          i2_q  <= i2_d;
          dac_q <= ~i2_d[IW-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sigma_delta.sv
// tb_audio_sigma_delta: three modulator configurations driven from one stimulus stream.
// Expected outputs come from an integer-arithmetic model and are queued per clock edge.
// A negedge monitor drains the queue and compares dac_out and sample_ready.
module tb_audio_sigma_delta;

  localparam int NDUT  = 3;
  localparam int W     = 16;
  localparam int MIDV  = 32768;
  localparam int CLAMP = 262144;   // 2^(W+2)

  // dut 0: ORDER 1, signed, CLK_DIV 1; dut 1: ORDER 2, signed, CLK_DIV 4; dut 2: ORDER 1, offset-binary, CLK_DIV 3
  function automatic int ord_of(input int m);
    return (m == 1) ? 2 : 1;
  endfunction
  function automatic int sgn_of(input int m);
    return (m == 2) ? 0 : 1;
  endfunction
  function automatic int div_of(input int m);
    return (m == 0) ? 1 : ((m == 1) ? 4 : 3);
  endfunction

  logic            clk;
  logic            reset_n;
  logic            sample_valid;
  logic            mute;
  logic [2*W-1:0]  sample_data;
  logic [NDUT-1:0] rdy_w;
  logic [1:0]      dac_w [NDUT];

  audio_sigma_delta #(.CHANNELS(2), .WIDTH(W), .SIGNED_IN(1), .ORDER(1), .CLK_DIV(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(rdy_w[0]),
    .sample_data(sample_data), .mute(mute), .dac_out(dac_w[0]));

  audio_sigma_delta #(.CHANNELS(2), .WIDTH(W), .SIGNED_IN(1), .ORDER(2), .CLK_DIV(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(rdy_w[1]),
    .sample_data(sample_data), .mute(mute), .dac_out(dac_w[1]));

  audio_sigma_delta #(.CHANNELS(2), .WIDTH(W), .SIGNED_IN(0), .ORDER(1), .CLK_DIV(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(rdy_w[2]),
    .sample_data(sample_data), .mute(mute), .dac_out(dac_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, idx, $time, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, required %0d..%0d", name, $time, got, lo, hi);
    end
  endtask

  // ------------------------------------------------------------ reference model
  int          m_cnt [NDUT];
  bit          m_pf  [NDUT];
  logic [31:0] m_pend[NDUT];
  int          m_act [NDUT][2];
  int          m_acc [NDUT][2];
  int          m_i1  [NDUT][2];
  int          m_i2  [NDUT][2];
  bit          m_dac [NDUT][2];

  typedef struct {
    int         idx;
    logic [1:0] dac;
    logic       rdy;
  } exp_t;
  exp_t sb_q[$];

  function automatic int clampi(input int v);
    if (v > CLAMP - 1) return CLAMP - 1;
    if (v < -CLAMP) return -CLAMP;
    return v;
  endfunction

  function automatic int off_of(input int m, input int raw);
    return (sgn_of(m) != 0) ? (raw + MIDV) % 65536 : raw;
  endfunction

  task automatic model_reset(input int m);
    m_cnt[m]  = 0;
    m_pf[m]   = 1'b0;
    m_pend[m] = '0;
    for (int ch = 0; ch < 2; ch++) begin
      m_act[m][ch] = MIDV;
      m_acc[m][ch] = 0;
      m_i1[m][ch]  = 0;
      m_i2[m][ch]  = 0;
      m_dac[m][ch] = 1'b0;
    end
  endtask

  // One clock edge of device m given the inputs currently applied.
  task automatic model_step(input int m);
    bit   tick, rdy;
    int   x, raw, fbv, s;
    exp_t e;
    tick = (m_cnt[m] % div_of(m)) == div_of(m) - 1;
    rdy  = !m_pf[m];
    if (tick) begin
      for (int ch = 0; ch < 2; ch++) begin
        raw = int'((m_pend[m] >> (16 * ch)) & 32'hFFFF);
        if (m_pf[m]) m_act[m][ch] = off_of(m, raw);
        x = mute ? MIDV : m_act[m][ch];
        if (ord_of(m) == 1) begin
          s = m_acc[m][ch] + x;
          m_dac[m][ch] = (s >= 65536);
          m_acc[m][ch] = s % 65536;
        end else begin
          fbv = m_dac[m][ch] ? MIDV : -MIDV;
          m_i1[m][ch] = clampi(m_i1[m][ch] + (x - MIDV) - fbv);
          m_i2[m][ch] = clampi(m_i2[m][ch] + m_i1[m][ch] - fbv);
          m_dac[m][ch] = (m_i2[m][ch] >= 0);
        end
      end
      m_pf[m] = 1'b0;
    end
    if (sample_valid && rdy) begin
      m_pend[m] = sample_data;
      m_pf[m]   = 1'b1;
    end
    m_cnt[m]++;
    e.idx = m;
    e.dac = {m_dac[m][1], m_dac[m][0]};
    e.rdy = !m_pf[m];
    sb_q.push_back(e);
  endtask

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("dac_out", e.idx, 32'(dac_w[e.idx]), 32'(e.dac));
      check("sample_ready", e.idx, 32'(rdy_w[e.idx]), 32'(e.rdy));
    end
  end

  // ------------------------------------------------------------ stimulus
  int n_acc_b;
  int low_run;
  int max_low;

  task automatic cycle(input logic v, input logic [31:0] d, input logic mu);
    sample_valid = v;
    sample_data  = d;
    mute         = mu;
    if (v && rdy_w[1]) n_acc_b++;
    if (!rdy_w[1]) low_run++;
    else           low_run = 0;
    if (low_run > max_low) max_low = low_run;
    @(posedge clk);
    for (int m = 0; m < NDUT; m++) model_step(m);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    #1;
    for (int m = 0; m < NDUT; m++) begin
      check("rst_dac_out", m, 32'(dac_w[m]), 32'd0);
      check("rst_ready", m, 32'(rdy_w[m]), 32'd1);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int m = 0; m < NDUT; m++) model_reset(m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic mute_r;
    int   ones;
    int   zeros;
    bit   seen;
    reset_n      = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    mute         = 1'b0;
    n_acc_b      = 0;
    low_run      = 0;
    max_low      = 0;
    #1 reset_n = 1'b0;
    #2;
    for (int m = 0; m < NDUT; m++) begin
      check("reset_dac_out", m, 32'(dac_w[m]), 32'd0);
      check("reset_ready", m, 32'(rdy_w[m]), 32'd1);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int m = 0; m < NDUT; m++) model_reset(m);

    // Zero-valued signed frame then idle: first-order output settles to exact alternation.
    cycle(1'b1, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 32'h0, 1'b0);

    // Random frames, random valid gaps, occasional mute toggles.
    mute_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) mute_r = ~mute_r;
      cycle($urandom_range(0, 3) != 0, $urandom, mute_r);
    end

    // Valid held high: the divide-by-4 device takes one frame per tick.
    n_acc_b = 0;
    max_low = 0;
    low_run = 0;
    for (int i = 0; i < 400; i++) cycle(1'b1, $urandom, 1'b0);
    check_range("throughput_accepts", n_acc_b, 99, 101);
    check_range("ready_low_run", max_low, 1, 4);

    // Mute with 0x4000 active gives exact half density, then 0x4000 resumes (3/4 density).
    cycle(1'b1, 32'h4000_4000, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b0);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      ones += int'(dac_w[0][0]);
    end
    check_range("mute_density", ones, 2044, 2052);
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      ones += int'(dac_w[0][0]);
    end
    check_range("unmute_density", ones, 766, 770);

    // Reset while a frame is pending on the divide-by-4 device.
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      cycle(1'b1, $urandom, 1'b0);
      if (!rdy_w[1]) seen = 1'b1;
    end
    check("pending_before_reset", 1, 32'(seen), 32'd1);
    pulse_reset();

    // Full-scale positive into the second-order loop.
    cycle(1'b1, 32'h7FFF_7FFF, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'b0);
    zeros = 0;
    for (int i = 0; i < 6000; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      zeros += int'(!dac_w[1][0]);
    end
    check_range("fullscale_zero_cycles", zeros, 0, 6);

    // Short random tail after the reset to confirm normal operation resumed.
    for (int i = 0; i < 500; i++) cycle($urandom_range(0, 1) != 0, $urandom, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
